// File: rtl/ball_motion_ctrl_if.sv
// Avalon-MM slave bus bundle for ball_motion_ctrl.
//   address    : 2-bit register select
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit combinational read data (driven by the slave)
interface ball_motion_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Ball motion controller: advances a ball one velocity step per video frame,
// bounces off the left/right/top walls, flags ball-lost at the bottom and
// reflects off the paddle. CPU access through an Avalon-MM slave register map:
//   0 x_pos[10:0] RW, 1 y_pos[10:0] RW, 2 vel {vy[15:8], vx[7:0]} RW,
//   3 ctrl/status {busy RO, irq_en RW, lost W1C, run RW}.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   bus (slave)        : Avalon-MM register access, readdata combinational
//   frame_tick         : one-cycle pulse per video frame
//   paddle_hit         : one-cycle pulse, ball touched paddle
//   x_pos, y_pos       : ball position to the video pipeline
//   irq                : ball-lost interrupt (only with BALL_IRQ_EN)
// Optional feature macro: BALL_IRQ_EN (irq output and RW irq_en bit).
module ball_motion_ctrl #(
  parameter int unsigned X_LIMIT = 632,
  parameter int unsigned Y_LIMIT = 472
) (
  input  logic               clk,
  input  logic               reset_n,
  ball_motion_ctrl_if.slave  bus,
  input  logic               frame_tick,
  input  logic               paddle_hit,
  output logic [10:0]        x_pos,
  output logic [10:0]        y_pos
`ifdef BALL_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int unsigned POS_W  = 11;
  localparam int unsigned VEL_W  = 8;
  localparam int unsigned CALC_W = 13;
  localparam logic signed [CALC_W-1:0] X_LIM_S = CALC_W'(X_LIMIT);
  localparam logic signed [CALC_W-1:0] Y_LIM_S = CALC_W'(Y_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_STEP_X, S_STEP_Y, S_DONE} state_e;

  state_e                   state_q, state_d;
  logic [POS_W-1:0]         x_q, x_d, y_q, y_d;
  logic signed [VEL_W-1:0]  vx_q, vx_d, vy_q, vy_d;
  logic                     run_q, run_d, lost_q, lost_d;
  logic                     irq_en_q, irq_en_d, pend_q, pend_d;

  logic signed [CALC_W-1:0] nx, ny;
  logic                     wr_en, vy_down, busy;
  logic                     unused_wd;

  // Negation that maps -128 to +127 instead of wrapping.
  function automatic logic signed [VEL_W-1:0] neg_sat(input logic signed [VEL_W-1:0] v);
    if (v == 8'sh80) return 8'sh7f;
    return -v;
  endfunction

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign vy_down   = (vy_q > 8'sd0);
  assign busy      = (state_q != S_IDLE);
  assign nx        = $signed({2'b00, x_q}) + CALC_W'(vx_q);
  assign ny        = $signed({2'b00, y_q}) + CALC_W'(vy_q);
  assign unused_wd = ^{bus.writedata[31:16], bus.writedata[2]};

  // Next-state: FSM motion step first, then paddle, then CPU writes override.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    run_d    = run_q;
    lost_d   = lost_q;
    irq_en_d = irq_en_q;
    pend_d   = pend_q;

    case (state_q)
      S_IDLE: begin
        if (frame_tick && run_q) state_d = S_STEP_X;
      end
      S_STEP_X: begin
        state_d = S_STEP_Y;
        if (nx < 0) begin
          x_d  = '0;
          vx_d = neg_sat(vx_q);
        end else if (nx > X_LIM_S) begin
          x_d  = POS_W'(X_LIMIT);
          vx_d = neg_sat(vx_q);
        end else begin
          x_d  = nx[POS_W-1:0];
        end
      end
      S_STEP_Y: begin
        state_d = S_DONE;
        if (ny < 0) begin
          y_d  = '0;
          vy_d = neg_sat(vy_q);
        end else if (ny > Y_LIM_S) begin
          y_d    = POS_W'(Y_LIMIT);
          lost_d = 1'b1;
          run_d  = 1'b0;
        end else begin
          y_d    = ny[POS_W-1:0];
        end
        // vy is owned by the wall logic this cycle; defer the paddle bounce.
        if (paddle_hit && vy_down) pend_d = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
      end
    endcase

    // pend_q can only be set while in DONE, so it folds in here.
    if ((state_q != S_STEP_Y) && (paddle_hit || pend_q) && vy_down)
      vy_d = neg_sat(vy_q);

    if (wr_en) begin
      case (bus.address)
        2'd0: x_d = bus.writedata[POS_W-1:0];
        2'd1: y_d = bus.writedata[POS_W-1:0];
        2'd2: begin
          vx_d = $signed(bus.writedata[7:0]);
          vy_d = $signed(bus.writedata[15:8]);
        end
        2'd3: begin
          run_d  = bus.writedata[0];
          lost_d = lost_q & ~bus.writedata[1];
`ifdef BALL_IRQ_EN
          irq_en_d = bus.writedata[2];
`endif
        end
      endcase
    end

`ifndef BALL_IRQ_EN
    irq_en_d = 1'b0;
`endif
  end

  // State and register file.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      run_q    <= 1'b0;
      lost_q   <= 1'b0;
      irq_en_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      run_q    <= run_d;
      lost_q   <= lost_d;
      irq_en_q <= irq_en_d;
      pend_q   <= pend_d;
    end
  end

  // Combinational read mux, forced to zero while reset is held.
  always_comb begin
    bus.readdata = '0;
    if (reset_n) begin
      case (bus.address)
        2'd0: bus.readdata = 32'(x_q);
        2'd1: bus.readdata = 32'(y_q);
        2'd2: bus.readdata = {16'h0000, vy_q, vx_q};
        2'd3: bus.readdata = 32'({busy, irq_en_q, lost_q, run_q});
      endcase
    end
  end

  assign x_pos = x_q;
  assign y_pos = y_q;

`ifdef BALL_IRQ_EN
  assign irq = reset_n & lost_q & irq_en_q;
`endif

endmodule

// File: tb/tb_ball_motion_ctrl.sv
module tb_ball_motion_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_tick;
  logic        paddle_hit;
  logic [10:0] x_pos;
  logic [10:0] y_pos;
`ifdef BALL_IRQ_EN
  logic        irq;
`endif

  int passed = 0;
  int total  = 0;

  ball_motion_ctrl_if bus();

  ball_motion_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .frame_tick (frame_tick),
    .paddle_hit (paddle_hit),
    .x_pos      (x_pos),
    .y_pos      (y_pos)
`ifdef BALL_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h want 0x%0h", name, got, exp);
    else passed++;
  endtask

  // Full step from IDLE: tick edge, STEP_X, STEP_Y, DONE -> back in IDLE.
  task automatic do_step();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0;
    tick();
    chk("rst_x_pos", 32'(x_pos), 32'd0);
    chk("rst_y_pos", 32'(y_pos), 32'd0);
    cpu_read(2'd3, rd);
    chk("rst_ctrl_rd", rd, 32'd0);
    #2 reset_n = 1'b1;
    tick();
    cpu_read(2'd2, rd);
    chk("rst_vel", rd, 32'd0);
  endtask

  task automatic test_basic_step();
    logic [31:0] rd;
    int busy_cnt;
    cpu_write(2'd0, 32'd100);
    cpu_write(2'd1, 32'd100);
    cpu_write(2'd2, 32'h0000_FD05);
    cpu_write(2'd3, 32'h1);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cpu_read(2'd3, rd);
      if (rd[3]) busy_cnt++;
      tick();
    end
    chk("basic_busy_cycles", 32'(busy_cnt), 32'd3);
    chk("basic_x", 32'(x_pos), 32'd105);
    chk("basic_y", 32'(y_pos), 32'd97);
  endtask

  task automatic test_walls();
    logic [31:0] rd;
    cpu_write(2'd1, 32'd100);
    cpu_write(2'd0, 32'd2);
    cpu_write(2'd2, 32'h0000_00FB);
    do_step();
    chk("left_x", 32'(x_pos), 32'd0);
    cpu_read(2'd2, rd);
    chk("left_vel", rd, 32'h0000_0005);
    cpu_write(2'd0, 32'd630);
    do_step();
    chk("right_x", 32'(x_pos), 32'd632);
    cpu_read(2'd2, rd);
    chk("right_vel", rd, 32'h0000_00FB);
    cpu_write(2'd0, 32'd100);
    cpu_write(2'd2, 32'h0000_0080);
    do_step();
    chk("sat_x", 32'(x_pos), 32'd0);
    cpu_read(2'd2, rd);
    chk("sat_vel", rd, 32'h0000_007F);
    chk("walls_y", 32'(y_pos), 32'd100);
  endtask

  task automatic test_bottom_loss();
    logic [31:0] rd;
    cpu_write(2'd0, 32'd10);
    cpu_write(2'd1, 32'd470);
    cpu_write(2'd2, 32'h0000_0400);
`ifdef BALL_IRQ_EN
    cpu_write(2'd3, 32'h5);
`else
    cpu_write(2'd3, 32'h5);
`endif
    do_step();
    chk("loss_y", 32'(y_pos), 32'd472);
    cpu_read(2'd3, rd);
`ifdef BALL_IRQ_EN
    chk("loss_ctrl", rd, 32'h6);
    chk("loss_irq", 32'(irq), 32'd1);
`else
    chk("loss_ctrl", rd, 32'h2);
`endif
    do_step();
    chk("loss_nomove_y", 32'(y_pos), 32'd472);
    chk("loss_nomove_x", 32'(x_pos), 32'd10);
`ifdef BALL_IRQ_EN
    cpu_write(2'd3, 32'h6);
    cpu_read(2'd3, rd);
    chk("loss_w1c", rd, 32'h4);
    chk("loss_irq_clr", 32'(irq), 32'd0);
`else
    cpu_write(2'd3, 32'h2);
    cpu_read(2'd3, rd);
    chk("loss_w1c", rd, 32'h0);
`endif
  endtask

  task automatic test_paddle();
    logic [31:0] rd;
    cpu_write(2'd1, 32'd100);
    cpu_write(2'd2, 32'h0000_0300);
    cpu_write(2'd3, 32'h1);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
    paddle_hit = 1'b1;
    tick();
    paddle_hit = 1'b0;
    cpu_read(2'd2, rd);
    chk("paddle_pending", rd, 32'h0000_0300);
    tick();
    cpu_read(2'd2, rd);
    chk("paddle_done_vel", rd, 32'h0000_FD00);
    chk("paddle_y", 32'(y_pos), 32'd103);
    paddle_hit = 1'b1;
    tick();
    paddle_hit = 1'b0;
    cpu_read(2'd2, rd);
    chk("paddle_up_ignored", rd, 32'h0000_FD00);
    cpu_write(2'd2, 32'h0000_0300);
    paddle_hit = 1'b1;
    tick();
    paddle_hit = 1'b0;
    cpu_read(2'd2, rd);
    chk("paddle_idle_vel", rd, 32'h0000_FD00);
  endtask

  task automatic test_collision();
    logic [31:0] rd;
    cpu_write(2'd0, 32'd200);
    cpu_write(2'd2, 32'h0000_0005);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    cpu_write(2'd0, 32'd50);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    repeat (3) tick();
    chk("coll_cpu_wins_x", 32'(x_pos), 32'd50);
    cpu_read(2'd3, rd);
    chk("coll_tick_ignored", rd, 32'h1);
  endtask

  task automatic test_run_clear_mid_step();
    logic [31:0] rd;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    cpu_write(2'd3, 32'h0);
    repeat (3) tick();
    chk("runclr_x", 32'(x_pos), 32'd55);
    cpu_read(2'd3, rd);
    chk("runclr_ctrl", rd, 32'h0);
    do_step();
    chk("runclr_nomove", 32'(x_pos), 32'd55);
  endtask

  task automatic test_reset_mid_step();
    logic [31:0] rd;
    cpu_write(2'd1, 32'd40);
    cpu_write(2'd2, 32'h0000_0303);
    cpu_write(2'd3, 32'h1);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_x", 32'(x_pos), 32'd0);
    chk("rstmid_y", 32'(y_pos), 32'd0);
    cpu_read(2'd2, rd);
    chk("rstmid_rd_zero", rd, 32'd0);
    tick();
    #2 reset_n = 1'b1;
    tick();
    cpu_read(2'd2, rd);
    chk("rstmid_vel", rd, 32'd0);
    cpu_read(2'd3, rd);
    chk("rstmid_ctrl", rd, 32'd0);
    tick();
    chk("rstmid_x_hold", 32'(x_pos), 32'd0);
  endtask

  task automatic test_irq_en_bit();
    logic [31:0] rd;
    cpu_write(2'd3, 32'h4);
    cpu_read(2'd3, rd);
`ifdef BALL_IRQ_EN
    chk("irq_en_rw", rd, 32'h4);
`else
    chk("irq_en_absent", rd, 32'h0);
`endif
    cpu_write(2'd3, 32'h0);
  endtask

  initial begin
    reset_n        = 1'b0;
    frame_tick     = 1'b0;
    paddle_hit     = 1'b0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    test_reset();
    test_basic_step();
    test_walls();
    test_bottom_loss();
    test_paddle();
    test_collision();
    test_run_clear_mid_step();
    test_reset_mid_step();
    test_irq_en_bit();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ball_motion_ctrl.md
BALL_MOTION_CTRL -- requirements
Module: ball_motion_ctrl

Interface
REQ-001 Parameter X_LIMIT, default 632, maximum legal x position (screen width 640 minus ball size 8).
REQ-002 Parameter Y_LIMIT, default 472, maximum legal y position (screen height 480 minus ball size 8).
REQ-003 Port clk  in  1  single clock for all logic.
REQ-004 Port reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port address  in  2  Avalon-MM slave register select.
REQ-006 Port chipselect  in  1  slave select.
REQ-007 Port write_n  in  1  active-low write strobe.
REQ-008 Port writedata  in  32  write data.
REQ-009 Port readdata  out  32  combinational read data, zero-extended.
REQ-010 Port frame_tick  in  1  one-cycle pulse per video frame.
REQ-011 Port paddle_hit  in  1  one-cycle pulse, ball touched paddle.
REQ-012 Port x_pos  out  11  ball x position to the video pipeline.
REQ-013 Port y_pos  out  11  ball y position to the video pipeline.
REQ-014 Port irq  out  1  ball-lost interrupt; present only with BALL_IRQ_EN.

Function
REQ-015 Register map SHALL be: 0 x_pos[10:0] RW; 1 y_pos[10:0] RW; 2 vel RW, vx signed[7:0], vy signed[15:8]; 3 ctrl/status, bit0 run RW, bit1 lost W1C, bit2 irq_en RW, bit3 busy RO.
REQ-016 A write SHALL occur when chipselect=1 and write_n=0, taking effect on the next clk edge.
REQ-017 The FSM SHALL have states IDLE, STEP_X, STEP_Y, DONE, with one cycle per state.
REQ-018 IDLE SHALL go to STEP_X on frame_tick=1 with run=1; otherwise it SHALL stay in IDLE.
REQ-019 frame_tick SHALL be ignored outside IDLE; busy SHALL be 1 in every state except IDLE.
REQ-020 STEP_X SHALL compute nx = x_pos + sign-extended vx in 13-bit signed arithmetic.
REQ-021 If nx<0 in STEP_X, x_pos SHALL be set to 0 and vx SHALL be negated.
REQ-022 If nx>X_LIMIT in STEP_X, x_pos SHALL be set to X_LIMIT and vx SHALL be negated.
REQ-023 Otherwise STEP_X SHALL set x_pos to nx[10:0].
REQ-024 STEP_Y SHALL compute ny the same way from vy; if ny<0, y_pos SHALL be set to 0 and vy negated.
REQ-025 If ny>Y_LIMIT in STEP_Y, y_pos SHALL be set to Y_LIMIT, lost SHALL be set to 1, and run SHALL be cleared to 0.
REQ-026 paddle_hit=1 with vy>0 (moving down) SHALL negate vy on the next edge in any state except STEP_Y; in STEP_Y it SHALL be held pending and applied in DONE.
REQ-027 Negating -128 SHALL give +127 (saturate).
REQ-028 A CPU write and an FSM update to the same register in the same cycle SHALL resolve with the CPU write winning; the FSM result for that register SHALL be discarded.
REQ-029 Clearing run mid-step SHALL let the current step complete through DONE, then the FSM SHALL stay in IDLE.
REQ-030 x_pos and y_pos outputs SHALL be the register values directly, with no added latency.

Reset
REQ-031 reset_n=0 SHALL asynchronously clear x_pos, y_pos, vel, run, lost, irq_en and the pending paddle flag, and set the FSM to IDLE.
REQ-032 readdata and irq SHALL read 0 while reset_n=0.
REQ-033 Reset assertion mid-step SHALL abort the step with no partial update retained.

Configuration
REQ-034 With macro BALL_IRQ_EN defined, irq SHALL equal lost AND irq_en, and ctrl bit2 SHALL be RW.
REQ-035 Without BALL_IRQ_EN, the irq port SHALL be absent, bit2 SHALL read 0, and writes to bit2 SHALL be ignored.

Verification
REQ-036 Basic step: x=100, y=100, vx=+5, vy=-3, run=1, one frame_tick -> x=105, y=97 four cycles later, busy high for 3 cycles.
REQ-037 Left wall: x=2, vx=-5 -> x=0, vx=+5; right wall: x=630, vx=+5 -> x=632, vx=-5.
REQ-038 Bottom loss: y=470, vy=+4 -> y=472, lost=1, run=0, irq=1 (macro defined, irq_en=1); a later frame_tick produces no motion; writing 1 to bit1 clears lost and irq.
REQ-039 Paddle hit: vy=+3 with paddle_hit pulsed during STEP_Y -> vy=-3 after DONE; with vy=-3, paddle_hit -> vy unchanged.
REQ-040 Collision: CPU write x=50 in the STEP_X cycle -> x reads 50; frame_tick during STEP_Y -> ignored; reset_n low during STEP_X -> all registers 0, FSM in IDLE.
